// File: rtl/bp_pkg.sv
// Shared definitions for the branch prediction unit: branch opcodes,
// BHT counter reset value and the branch-opcode classifier.
package bp_pkg;

   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGT   = 6'b000110;
   localparam logic [5:0] OP_BGE   = 6'b000111;
   localparam logic [5:0] OP_BLT   = 6'b001000;
   localparam logic [5:0] OP_BLE   = 6'b001001;
   localparam logic [5:0] OP_BLTU  = 6'b001010;
   localparam logic [5:0] OP_BGTU  = 6'b001011;
   localparam logic [5:0] OP_BGEU  = 6'b001100;
   localparam logic [5:0] OP_BLEQU = 6'b001101;

   localparam logic [1:0] CTR_INIT = 2'b01;

   // Branch opcodes occupy one contiguous range.
   function automatic logic is_branch(input logic [5:0] opcode);
      return (opcode >= OP_BEQ) && (opcode <= OP_BLEQU);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation for the mini-MIPS branch opcodes.
module branch_cond_eval
   import bp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        opcode,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic              taken,
   output logic              is_br
);

   logic signed [DATA_W-1:0] rs_s;
   logic signed [DATA_W-1:0] rt_s;

   assign rs_s  = rs;
   assign rt_s  = rt;
   assign is_br = is_branch(opcode);

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:   taken = (rs == rt);
         OP_BNE:   taken = (rs != rt);
         OP_BGT:   taken = (rs_s >  rt_s);
         OP_BGE:   taken = (rs_s >= rt_s);
         OP_BLT:   taken = (rs_s <  rt_s);
         OP_BLE:   taken = (rs_s <= rt_s);
         OP_BLTU:  taken = (rs <  rt);
         OP_BGTU:  taken = (rs >  rt);
         OP_BGEU:  taken = (rs >= rt);
         OP_BLEQU: taken = (rs <= rt);
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction (BHT + tagged BTB) and resolution with registered redirect.
// Optional perf counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              res_valid_i,
   input  logic [PC_W-1:0]   res_pc,
   input  logic [5:0]        res_opcode,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [15:0]       imm16,
   input  logic              res_pred_taken,
   output logic              res_valid_o,
   output logic              res_taken,
   output logic [PC_W-1:0]   res_target,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc
`ifdef BRANCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_branches,
   output logic [31:0]       perf_mispredicts
`endif
);

   localparam int ENTRIES = 1 << IDX_W;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   logic [1:0]      bht        [ENTRIES];
   logic [ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0] btb_tag    [ENTRIES];
   logic [PC_W-1:0] btb_target [ENTRIES];

   // Fetch-side lookup (reads pre-update table state)
   logic [IDX_W-1:0] fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic             fetch_hit;

   assign fetch_idx   = fetch_pc[IDX_W+1:2];
   assign fetch_tag   = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign fetch_hit   = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
   assign pred_taken  = fetch_hit && bht[fetch_idx][1];
   assign pred_target = pred_taken ? btb_target[fetch_idx] : '0;

   // Resolve stage p0: condition, target and redirect
   logic [IDX_W-1:0] res_idx;
   logic [TAG_W-1:0] res_tag;
   logic             cond_taken;
   logic             is_br_p0;
   logic             taken_p0;
   logic [PC_W-1:0]  pc_plus4_p0;
   logic [PC_W-1:0]  target_p0;
   logic             mispredict_p0;
   logic [PC_W-1:0]  redirect_p0;
   logic             unused_pc_bits;

   assign res_idx = res_pc[IDX_W+1:2];
   assign res_tag = res_pc[IDX_W+TAG_W+1:IDX_W+2];

   branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
      .opcode (res_opcode),
      .rs     (rs_data),
      .rt     (rt_data),
      .taken  (cond_taken),
      .is_br  (is_br_p0)
   );

   assign taken_p0      = is_br_p0 && cond_taken;
   assign pc_plus4_p0   = res_pc + PC_W'(4);
   assign target_p0     = pc_plus4_p0 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
   // Non-branches are never taken, so this also covers the non-branch case.
   assign mispredict_p0 = (taken_p0 != res_pred_taken);
   assign redirect_p0   = taken_p0 ? target_p0 : pc_plus4_p0;
   assign unused_pc_bits = ^{fetch_pc, res_pc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
         btb_valid <= '0;
      end else if (res_valid_i) begin
         if (is_br_p0) begin
            if (taken_p0) begin
               bht[res_idx]       <= ctr_inc(bht[res_idx]);
               btb_valid[res_idx] <= 1'b1;
            end else begin
               bht[res_idx]       <= ctr_dec(bht[res_idx]);
            end
         end else if (res_pred_taken && (btb_tag[res_idx] == res_tag)) begin
            btb_valid[res_idx] <= 1'b0;
         end
      end
   end

   // Tag/target storage needs no reset: entries are gated by btb_valid.
   always_ff @(posedge clk) begin
      if (res_valid_i && taken_p0) begin
         btb_tag[res_idx]    <= res_tag;
         btb_target[res_idx] <= target_p0;
      end
   end

   // Resolve stage p1: registered outcome
   logic            vld_p1;
   logic            taken_p1;
   logic [PC_W-1:0] target_p1;
   logic            mispredict_p1;
   logic [PC_W-1:0] redirect_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1        <= 1'b0;
         taken_p1      <= 1'b0;
         target_p1     <= '0;
         mispredict_p1 <= 1'b0;
         redirect_p1   <= '0;
      end else begin
         vld_p1        <= res_valid_i;
         taken_p1      <= res_valid_i && taken_p0;
         target_p1     <= target_p0;
         mispredict_p1 <= res_valid_i && mispredict_p0;
         redirect_p1   <= redirect_p0;
      end
   end

   assign res_valid_o = vld_p1;
   assign res_taken   = taken_p1;
   assign res_target  = target_p1;
   assign mispredict  = mispredict_p1;
   assign redirect_pc = redirect_p1;

`ifdef BRANCH_PERF_CNT_EN
   logic br_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_p1            <= 1'b0;
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         br_p1 <= res_valid_i && is_br_p0;
         if (vld_p1 && br_p1)         perf_branches    <= cnt_sat_inc(perf_branches);
         if (vld_p1 && mispredict_p1) perf_mispredicts <= cnt_sat_inc(perf_mispredicts);
      end
   end
`else
   // Counters compiled out; the saturating helper stays unused.
   logic [31:0] unused_cnt;
   assign unused_cnt = cnt_sat_inc(32'd0);
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid_i;
   logic [31:0] res_pc;
   logic [5:0]  res_opcode;
   logic [31:0] rs_data, rt_data;
   logic [15:0] imm16;
   logic        res_pred_taken;
   logic        res_valid_o, res_taken, mispredict;
   logic [31:0] res_target, redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int checks = 0;
   int failures = 0;

   branch_predict_unit dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .res_valid_i(res_valid_i), .res_pc(res_pc),
      .res_opcode(res_opcode), .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
      .res_pred_taken(res_pred_taken), .res_valid_o(res_valid_o), .res_taken(res_taken),
      .res_target(res_target), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic start_resolve(input logic [31:0] pc, input logic [5:0] op,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic pred);
      res_pc = pc; res_opcode = op; rs_data = rs; rt_data = rt;
      imm16 = imm; res_pred_taken = pred; res_valid_i = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      res_valid_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; res_valid_i = 1'b0; fetch_pc = 32'h0;
      start_resolve(32'h0, 6'h0, 32'h0, 32'h0, 16'h0, 1'b0);
      res_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", res_valid_o); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0h exp=0", res_taken); end
      checks++; if (res_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%0h exp=0", res_target); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%0h exp=0", mispredict); end
      checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect got=%0h exp=0", redirect_pc); end
      rst = 1'b0;
      fetch_pc = 32'h100;
      #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken got=%0h exp=0", pred_taken); end
      checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL rst_pred_target got=%0h exp=0", pred_target); end
   endtask

   task automatic test_beq();
      @(negedge clk);
      fetch_pc = 32'h100;
      start_resolve(32'h100, 6'b000100, 32'd5, 32'd5, 16'h0004, 1'b0);
      #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL beq_pre_update_pred got=%0h exp=0", pred_taken); end
      step();
      checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL beq_valid got=%0h exp=1", res_valid_o); end
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0h exp=1", res_taken); end
      checks++; if (res_target !== 32'h114) begin failures++; $display("FAIL beq_target got=%0h exp=114", res_target); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL beq_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h114) begin failures++; $display("FAIL beq_redirect got=%0h exp=114", redirect_pc); end
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL beq_pred_taken got=%0h exp=1", pred_taken); end
      checks++; if (pred_target !== 32'h114) begin failures++; $display("FAIL beq_pred_target got=%0h exp=114", pred_target); end
      @(negedge clk); #1;
      checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL beq_valid_pulse got=%0h exp=0", res_valid_o); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL beq_mispredict_idle got=%0h exp=0", mispredict); end
   endtask

   task automatic test_signed_unsigned();
      start_resolve(32'h208, 6'b000110, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b0);
      step();
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL sgt_taken got=%0h exp=0", res_taken); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL sgt_mispredict got=%0h exp=0", mispredict); end
      checks++; if (redirect_pc !== 32'h20C) begin failures++; $display("FAIL sgt_redirect got=%0h exp=20c", redirect_pc); end
      start_resolve(32'h208, 6'b001011, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b0);
      step();
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL ugt_taken got=%0h exp=1", res_taken); end
      checks++; if (res_target !== 32'h24C) begin failures++; $display("FAIL ugt_target got=%0h exp=24c", res_target); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL ugt_mispredict got=%0h exp=1", mispredict); end
      start_resolve(32'h208, 6'b001101, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b1);
      step();
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL uleq_taken got=%0h exp=0", res_taken); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL uleq_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h20C) begin failures++; $display("FAIL uleq_redirect got=%0h exp=20c", redirect_pc); end
      start_resolve(32'h208, 6'b001000, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b1);
      step();
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL slt_taken got=%0h exp=1", res_taken); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL slt_mispredict got=%0h exp=0", mispredict); end
   endtask

   task automatic test_saturation();
      fetch_pc = 32'h40C;
      for (int i = 0; i < 4; i++) begin
         start_resolve(32'h40C, 6'b000100, 32'd7, 32'd7, 16'h0002, 1'b1);
         step();
      end
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_pred_after_taken got=%0h exp=1", pred_taken); end
      checks++; if (pred_target !== 32'h418) begin failures++; $display("FAIL sat_target got=%0h exp=418", pred_target); end
      start_resolve(32'h40C, 6'b000100, 32'd1, 32'd2, 16'h0002, 1'b1);
      step();
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL sat_nt_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h410) begin failures++; $display("FAIL sat_nt_redirect got=%0h exp=410", redirect_pc); end
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_ctr2_pred got=%0h exp=1", pred_taken); end
      start_resolve(32'h40C, 6'b000100, 32'd1, 32'd2, 16'h0002, 1'b1);
      #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_same_cycle_pred got=%0h exp=1", pred_taken); end
      step();
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_ctr1_pred got=%0h exp=0", pred_taken); end
      for (int i = 0; i < 2; i++) begin
         start_resolve(32'h40C, 6'b000100, 32'd1, 32'd2, 16'h0002, 1'b0);
         step();
      end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_ctr0_pred got=%0h exp=0", pred_taken); end
      start_resolve(32'h40C, 6'b000100, 32'd7, 32'd7, 16'h0002, 1'b0);
      step();
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_floor_pred got=%0h exp=0", pred_taken); end
   endtask

   task automatic test_nonbranch();
      fetch_pc = 32'h200;
      #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_pred got=%0h exp=0", pred_taken); end
      start_resolve(32'h200, 6'b100011, 32'd0, 32'd0, 16'h0004, 1'b1);
      step();
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL nb_alias_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h204) begin failures++; $display("FAIL nb_alias_redirect got=%0h exp=204", redirect_pc); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL nb_taken got=%0h exp=0", res_taken); end
      fetch_pc = 32'h100;
      #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL nb_entry_kept got=%0h exp=1", pred_taken); end
      start_resolve(32'h100, 6'b100011, 32'd0, 32'd0, 16'h0004, 1'b1);
      step();
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL nb_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL nb_redirect got=%0h exp=104", redirect_pc); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nb_invalidated got=%0h exp=0", pred_taken); end
      start_resolve(32'h100, 6'b100011, 32'd0, 32'd0, 16'h0004, 1'b0);
      step();
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL nb_nopred_mispredict got=%0h exp=0", mispredict); end
      start_resolve(32'h0, 6'b000100, 32'd3, 32'd3, 16'hFFFF, 1'b0);
      step();
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL wrap_taken got=%0h exp=1", res_taken); end
      checks++; if (res_target !== 32'h0) begin failures++; $display("FAIL wrap_target got=%0h exp=0", res_target); end
      checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_redirect got=%0h exp=0", redirect_pc); end
   endtask

   task automatic test_back_to_back();
      start_resolve(32'h510, 6'b000101, 32'd1, 32'd2, 16'h0001, 1'b0);
      step();
      start_resolve(32'h614, 6'b000100, 32'd1, 32'd2, 16'h0001, 1'b1);
      checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_a_valid got=%0h exp=1", res_valid_o); end
      checks++; if (res_target !== 32'h518) begin failures++; $display("FAIL b2b_a_target got=%0h exp=518", res_target); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL b2b_a_mispredict got=%0h exp=1", mispredict); end
      step();
      checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_b_valid got=%0h exp=1", res_valid_o); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL b2b_b_taken got=%0h exp=0", res_taken); end
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL b2b_b_mispredict got=%0h exp=1", mispredict); end
      checks++; if (redirect_pc !== 32'h618) begin failures++; $display("FAIL b2b_b_redirect got=%0h exp=618", redirect_pc); end
      @(negedge clk); #1;
      checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%0h exp=0", res_valid_o); end
      fetch_pc = 32'h510;
      #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL b2b_a_trained got=%0h exp=1", pred_taken); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_resolve(32'h710, 6'b000100, 32'd9, 32'd9, 16'h0000, 1'b0);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_valid_i = 1'b0;
      #1;
      checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0h exp=0", res_valid_o); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL midrst_mispredict got=%0h exp=0", mispredict); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid_after got=%0h exp=0", res_valid_o); end
      fetch_pc = 32'h510; #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL midrst_pred_510 got=%0h exp=0", pred_taken); end
      fetch_pc = 32'h40C; #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL midrst_pred_40c got=%0h exp=0", pred_taken); end
      fetch_pc = 32'h710; #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL midrst_pred_710 got=%0h exp=0", pred_taken); end
      checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL midrst_pred_target got=%0h exp=0", pred_target); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_signed_unsigned();
      test_saturation();
      test_nonbranch();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
